// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - debounced start/lap stopwatch with BCD count, lap hold and scanned 7-segment output
module lap_debounce #(
  parameter int DIV = 100_000,
  parameter int LEN = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic press_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]  cnt_q;
  logic [LEN-1:0] sh_q;
  logic           filt_q;
  logic           filt_dly_q;
  logic           strobe;

  assign strobe  = (cnt_q == CW'(DIV - 1));
  assign press_o = filt_q & ~filt_dly_q;

  // Filtered level only moves on a unanimous window; mixed windows hold it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      sh_q       <= '0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
    end else begin
      cnt_q <= strobe ? '0 : cnt_q + 1'b1;
      if (strobe) sh_q <= {sh_q[LEN-2:0], raw_i};
      if (&sh_q) filt_q <= 1'b1;
      else if (~|sh_q) filt_q <= 1'b0;
      filt_dly_q <= filt_q;
    end
  end
endmodule

module lap_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1_000_000,
  parameter int DEB_DIV  = 100_000,
  parameter int DEB_LEN  = 5,
  parameter int SCAN_DIV = 50_000
) (
  input  logic              clk0,
  input  logic              reset_sw,
  input  logic              start_sw,
  input  logic              lap_sw,
  output logic [1:0]        led,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] line,
  output logic              dp
);
  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    dig_q [DIGITS];
  logic [3:0]    dig_d [DIGITS];
  logic [3:0]    lap_q [DIGITS];
  logic [3:0]    lap_d [DIGITS];
  logic          ovf_q, ovf_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          start_p, lap_p, cnt_en, tick, carry;
  logic [3:0]    disp_dig;

  lap_debounce #(.DIV(DEB_DIV), .LEN(DEB_LEN)) u_deb_start (
    .clk_i(clk0), .rst_i(reset_sw), .raw_i(start_sw), .press_o(start_p));
  lap_debounce #(.DIV(DEB_DIV), .LEN(DEB_LEN)) u_deb_lap (
    .clk_i(clk0), .rst_i(reset_sw), .raw_i(lap_sw), .press_o(lap_p));

  function automatic logic is_on(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'b0111111;
      4'd1: seg7 = 7'b0000110;
      4'd2: seg7 = 7'b1011011;
      4'd3: seg7 = 7'b1001111;
      4'd4: seg7 = 7'b1100110;
      4'd5: seg7 = 7'b1101101;
      4'd6: seg7 = 7'b1111101;
      4'd7: seg7 = 7'b0000111;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_p) state_d = RUN;
      RUN:  if (start_p) state_d = STOP; else if (lap_p) state_d = LAP;
      LAP:  if (start_p) state_d = STOP; else if (lap_p) state_d = RUN;
      STOP: if (start_p) state_d = RUN;  else if (lap_p) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counting needs the state active on both sides of the edge, so the stop
    // edge issues no tick and the resume edge does not advance the phase.
    cnt_en  = is_on(state_q) && is_on(state_d);
    tick    = cnt_en && (presc_q == PW'(TICK_DIV - 1));
    presc_d = presc_q;
    if (cnt_en) presc_d = tick ? '0 : presc_q + 1'b1;

    carry = tick;
    ovf_d = ovf_q;
    for (int k = 0; k < DIGITS; k++) begin
      dig_d[k] = dig_q[k];
      lap_d[k] = lap_q[k];
      if (carry) dig_d[k] = (dig_q[k] == 4'd9) ? 4'd0 : dig_q[k] + 4'd1;
      carry = carry && (dig_q[k] == 4'd9);
      if (state_q == RUN && state_d == LAP) lap_d[k] = dig_q[k];
    end
    if (carry) ovf_d = 1'b1;

    if (state_d == IDLE) begin
      presc_d = '0;
      ovf_d   = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
        dig_d[k] = 4'd0;
        lap_d[k] = 4'd0;
      end
    end

    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    disp_dig = (state_d == LAP) ? lap_d[idx_d] : dig_d[idx_d];
  end

  always_ff @(posedge clk0) begin
    if (reset_sw) begin
      state_q <= IDLE;
      presc_q <= '0;
      ovf_q   <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      for (int k = 0; k < DIGITS; k++) begin
        dig_q[k] <= 4'd0;
        lap_q[k] <= 4'd0;
      end
      led  <= 2'b00;
      seg  <= 7'b0111111;
      line <= DIGITS'(1);
      dp   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ovf_q   <= ovf_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      for (int k = 0; k < DIGITS; k++) begin
        dig_q[k] <= dig_d[k];
        lap_q[k] <= lap_d[k];
      end
      led  <= {ovf_d, is_on(state_d)};
      seg  <= seg7(disp_dig);
      line <= DIGITS'(1) << idx_d;
      dp   <= (idx_d == IW'(1));
    end
  end
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - directed plus random bench for lap_stopwatch against an elapsed-tick model
module tb_lap_stopwatch;
  localparam int DIGITS   = 4;
  localparam int DEB_LEN  = 3;
  localparam int SCAN_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;
  localparam logic [6:0] SEGTAB [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                         7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                         7'b1111111, 7'b1101111};

  logic clk0 = 1'b0;
  logic reset_sw, start_sw, lap_sw;
  logic [1:0] led0, led1;
  logic [6:0] seg0, seg1;
  logic [3:0] line0, line1;
  logic       dp0, dp1;

  always #5 clk0 = ~clk0;

  // Second instance ticks every cycle so the 9999 -> 0000 overflow is reachable.
  lap_stopwatch #(.DIGITS(4), .TICK_DIV(10), .DEB_DIV(1), .DEB_LEN(3), .SCAN_DIV(4)) dut0 (
    .clk0(clk0), .reset_sw(reset_sw), .start_sw(start_sw), .lap_sw(lap_sw),
    .led(led0), .seg(seg0), .line(line0), .dp(dp0));
  lap_stopwatch #(.DIGITS(4), .TICK_DIV(1), .DEB_DIV(1), .DEB_LEN(3), .SCAN_DIV(4)) dut1 (
    .clk0(clk0), .reset_sw(reset_sw), .start_sw(start_sw), .lap_sw(lap_sw),
    .led(led1), .seg(seg1), .line(line1), .dp(dp1));

  int compared = 0, mismatched = 0;
  int run1 [2], run0 [2];
  bit filt [2], fprev [2];
  int st [2], phase [2], ticks [2], lapv [2];
  int tdiv [2] = '{10, 1};
  int frame;

  function automatic bit m_on(input int s);
    return (s == M_RUN) || (s == M_LAP);
  endfunction

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  task automatic model_edge(input bit rst, input bit raw_s, input bit raw_l);
    bit p [2];
    bit raw [2];
    int nst;
    raw[0] = raw_s;
    raw[1] = raw_l;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        run1[s] = 0; run0[s] = DEB_LEN; filt[s] = 0; fprev[s] = 0;
        st[s] = M_IDLE; phase[s] = 0; ticks[s] = 0; lapv[s] = 0;
      end
      frame = 0;
      return;
    end
    for (int s = 0; s < 2; s++) begin
      p[s] = filt[s] && !fprev[s];
      fprev[s] = filt[s];
      if (run1[s] >= DEB_LEN) filt[s] = 1;
      else if (run0[s] >= DEB_LEN) filt[s] = 0;
      if (raw[s]) begin run1[s]++; run0[s] = 0; end
      else begin run0[s]++; run1[s] = 0; end
    end
    frame++;
    for (int d = 0; d < 2; d++) begin
      nst = st[d];
      if (p[0]) nst = (st[d] == M_IDLE || st[d] == M_STOP) ? M_RUN : M_STOP;
      else if (p[1]) begin
        if (st[d] == M_RUN) nst = M_LAP;
        else if (st[d] == M_LAP) nst = M_RUN;
        else if (st[d] == M_STOP) nst = M_IDLE;
      end
      if (st[d] == M_RUN && nst == M_LAP) lapv[d] = ticks[d] % 10000;
      if (m_on(st[d]) && m_on(nst)) begin
        phase[d]++;
        if (phase[d] == tdiv[d]) begin phase[d] = 0; ticks[d]++; end
      end
      st[d] = nst;
      if (st[d] == M_IDLE) begin phase[d] = 0; ticks[d] = 0; lapv[d] = 0; end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int idx, disp, dig;
    for (int d = 0; d < 2; d++) begin
      idx  = (frame / SCAN_DIV) % DIGITS;
      disp = (st[d] == M_LAP) ? lapv[d] : ticks[d] % 10000;
      dig  = (disp / pow10(idx)) % 10;
      check($sformatf("d%0d led f%0d", d, frame), (d == 0) ? led0 : led1,
            {ticks[d] >= 10000, m_on(st[d])});
      check($sformatf("d%0d seg f%0d", d, frame), (d == 0) ? seg0 : seg1, SEGTAB[dig]);
      check($sformatf("d%0d line f%0d", d, frame), (d == 0) ? line0 : line1, 32'd1 << idx);
      check($sformatf("d%0d dp f%0d", d, frame), (d == 0) ? dp0 : dp1, idx == 1);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk0);
      model_edge(reset_sw, start_sw, lap_sw);
      #1;
      check_all();
    end
  endtask

  task automatic press(input bit s, input bit l, input int hold, input int gap);
    start_sw = s;
    lap_sw   = l;
    cyc(hold);
    start_sw = 0;
    lap_sw   = 0;
    cyc(gap);
  endtask

  initial begin
    reset_sw = 1; start_sw = 0; lap_sw = 0;
    cyc(2);
    check("rst led", led0, 2'b00);
    check("rst line", line0, 4'b0001);
    check("rst seg", seg0, 7'b0111111);
    check("rst dp", dp0, 1'b0);
    reset_sw = 0;
    cyc(4);
    check("scan line", line0, 4'b0010);
    check("scan dp", dp0, 1'b1);

    press(1, 0, 5, 250);
    check("run led", led0, 2'b01);
    press(1, 0, 5, 30);
    check("stop led", led0, 2'b00);
    press(1, 0, 5, 160);
    press(0, 1, 5, 40);
    press(0, 1, 5, 20);
    press(1, 0, 5, 20);
    press(0, 1, 5, 20);

    press(1, 0, 2, 10);
    check("glitch idle led", led0, 2'b00);

    press(1, 0, 5, 10500);
    check("ovf led", led1, 2'b11);
    press(0, 1, 5, 30);
    press(0, 1, 5, 30);
    press(1, 1, 5, 20);
    check("start wins led", led0, 2'b00);
    press(0, 1, 5, 20);
    check("idle clears ovf", led1, 2'b00);

    press(1, 0, 5, 1370);
    press(0, 1, 5, 5);
    reset_sw = 1;
    cyc(1);
    reset_sw = 0;
    check("mid reset led", led0, 2'b00);
    check("mid reset seg", seg0, 7'b0111111);
    cyc(10);
    press(1, 0, 5, 40);

    for (int r = 0; r < 300; r++) begin
      start_sw = ($urandom_range(0, 3) == 0);
      lap_sw   = ($urandom_range(0, 3) == 0);
      reset_sw = ($urandom_range(0, 60) == 0);
      cyc($urandom_range(1, 12));
    end
    reset_sw = 0; start_sw = 0; lap_sw = 0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
